// File: rtl/iob_cache_front_end_fifo.sv
// Buffered IOb cache front-end: a request FIFO between the IOb slave
// port and the cache core / ctrl register file, with read-data return.
module iob_cache_front_end_fifo #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int USE_CTRL    = 0,
  parameter int CTRL_ADDR_W = 5,
  parameter int DEPTH_W     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cke_i,
  input  logic                       iob_valid_i,
  input  logic [ADDR_W-1:0]          iob_addr_i,
  input  logic [DATA_W-1:0]          iob_wdata_i,
  input  logic [DATA_W/8-1:0]        iob_wstrb_i,
  output logic                       iob_ready_o,
  output logic                       iob_rvalid_o,
  output logic [DATA_W-1:0]          iob_rdata_o,
  output logic                       req_valid_o,
  output logic                       req_ctrl_o,
  output logic [ADDR_W-USE_CTRL-1:0] req_addr_o,
  output logic [DATA_W-1:0]          req_wdata_o,
  output logic [DATA_W/8-1:0]        req_wstrb_o,
  input  logic                       req_ack_i,
  input  logic [DATA_W-1:0]          req_rdata_i,
  output logic [DEPTH_W:0]           level_o,
  output logic [31:0]                stall_cnt_o
);

  localparam int RA_W   = ADDR_W - USE_CTRL;
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0] LVL_FULL = (DEPTH_W+1)'(DEPTH);

  if (CTRL_ADDR_W > ADDR_W - 1) begin : g_cfg_err
    $error("CTRL_ADDR_W must not exceed ADDR_W-1");
  end

  typedef struct packed {
    logic              ctrl;
    logic [RA_W-1:0]   addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              we;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  entry_t             in_entry;
  entry_t             head;
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   level_q, level_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;
  logic               full;
  logic               push;
  logic               pop;
  logic               stall_inc;

  // Handshake decode; ready looks only at registered occupancy.
  always_comb begin
    full         = (level_q == LVL_FULL);
    iob_ready_o  = ~full & ~rst_i;
    req_valid_o  = (level_q != '0);
    push         = cke_i & iob_valid_i & iob_ready_o;
    pop          = cke_i & req_ack_i & req_valid_o & ~rst_i;
    stall_inc    = cke_i & iob_valid_i & ~iob_ready_o
                 & ~rst_i & ~(&stall_cnt_q);
    head         = mem_q[rd_ptr_q];
    iob_rvalid_o = pop & ~head.we;
    iob_rdata_o  = req_rdata_i;
    req_ctrl_o   = head.ctrl;
    req_addr_o   = head.addr;
    req_wdata_o  = head.wdata;
    req_wstrb_o  = head.wstrb;
    level_o      = level_q;
    stall_cnt_o  = stall_cnt_q;
  end

  // Pack the incoming request; the ctrl bit is stripped from the address.
  always_comb begin
    in_entry.ctrl  = (USE_CTRL != 0) && iob_addr_i[ADDR_W-1];
    in_entry.addr  = iob_addr_i[RA_W-1:0];
    in_entry.wdata = iob_wdata_i;
    in_entry.wstrb = iob_wstrb_i;
    in_entry.we    = |iob_wstrb_i;
  end

  // Next-state for storage, pointers, occupancy and stall counter.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    stall_cnt_d = stall_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (stall_inc) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Control state; reset wins over clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      stall_cnt_q <= '0;
    end else if (cke_i) begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload storage; contents are meaningless while the slot is free.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_iob_cache_front_end_fifo.sv
// Directed self-checking bench for iob_cache_front_end_fifo
// (USE_CTRL=1, DEPTH_W=2, 32-bit address/data).
module tb_iob_cache_front_end_fifo;

  logic        clk = 1'b0;
  logic        rst, cke, valid, ack;
  logic [31:0] addr, wdata, rdata_in;
  logic [3:0]  wstrb;
  logic        ready, rvalid, req_valid, req_ctrl;
  logic [31:0] rdata;
  logic [30:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  level;
  logic [31:0] stall;
  int          n_run  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  iob_cache_front_end_fifo #(
    .ADDR_W(32), .DATA_W(32), .USE_CTRL(1),
    .CTRL_ADDR_W(5), .DEPTH_W(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke),
    .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
    .iob_ready_o(ready), .iob_rvalid_o(rvalid),
    .iob_rdata_o(rdata), .req_valid_o(req_valid),
    .req_ctrl_o(req_ctrl), .req_addr_o(req_addr),
    .req_wdata_o(req_wdata), .req_wstrb_o(req_wstrb),
    .req_ack_i(ack), .req_rdata_i(rdata_in),
    .level_o(level), .stall_cnt_o(stall)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    valid = v;
    addr  = a;
    wdata = d;
    wstrb = s;
  endtask

  initial begin
    rst = 1'b1; cke = 1'b1; ack = 1'b0; rdata_in = '0;
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    check("rst_ready", ready, 0);
    check("rst_rvalid", rvalid, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", ready, 1);
    check("post_rst_req_valid", req_valid, 0);
    check("post_rst_level", level, 0);
    check("post_rst_stall", stall, 0);

    // 1: single read
    drive(1'b1, 32'h40, 32'h0, 4'h0);
    tick();
    drive(1'b0, '0, '0, '0);
    check("t1_req_valid", req_valid, 1);
    check("t1_req_addr", req_addr, 32'h40);
    check("t1_req_ctrl", req_ctrl, 0);
    check("t1_level1", level, 1);
    ack = 1'b1; rdata_in = 32'hCAFEF00D;
    #1;
    check("t1_rvalid", rvalid, 1);
    check("t1_rdata", rdata, 32'hCAFEF00D);
    tick();
    ack = 1'b0;
    #1;
    check("t1_level0", level, 0);
    check("t1_rvalid_off", rvalid, 0);

    // 2: five back-to-back writes, no ack
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4*i), 32'(i+1), 4'hF);
      tick();
    end
    drive(1'b1, 32'h110, 32'd5, 4'hF);
    #1;
    check("t2_full_level", level, 4);
    check("t2_full_ready", ready, 0);
    tick();
    tick();
    check("t2_stall2", stall, 2);
    ack = 1'b1;
    #1;
    check("t2_ack_ready_reg", ready, 0);
    check("t2_write_no_rvalid", rvalid, 0);
    check("t2_head0", req_addr, 32'h100);
    tick();
    ack = 1'b0;
    #1;
    check("t2_level3", level, 3);
    check("t2_stall3", stall, 3);
    check("t2_ready_again", ready, 1);
    tick();
    drive(1'b0, '0, '0, '0);
    check("t2_level4", level, 4);
    check("t2_stall_held", stall, 3);
    ack = 1'b1;
    for (int j = 1; j < 5; j++) begin
      #1;
      check("t2_drain_addr", req_addr, 32'h100 + 32'(4*j));
      check("t2_drain_wdata", req_wdata, 32'(j+1));
      check("t2_drain_wstrb", req_wstrb, 4'hF);
      check("t2_drain_rvalid", rvalid, 0);
      tick();
    end
    ack = 1'b0;
    #1;
    check("t2_empty", level, 0);

    // 3: push and ack every cycle, odd entries are reads
    drive(1'b1, 32'h200, 32'd0, 4'hF);
    tick();
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 32'h200 + 32'(4*k), 32'(k),
            (k % 2 == 1) ? 4'h0 : 4'h3);
      ack = 1'b1;
      rdata_in = 32'hD000 + 32'(k-1);
      #1;
      check("t3_level", level, 1);
      check("t3_head", req_addr, 32'h200 + 32'(4*(k-1)));
      check("t3_rvalid", rvalid, ((k-1) % 2 == 1) ? 1 : 0);
      if ((k-1) % 2 == 1)
        check("t3_rdata", rdata, 32'hD000 + 32'(k-1));
      tick();
    end
    drive(1'b0, '0, '0, '0);
    ack = 1'b0;
    #1;
    check("t3_level_end", level, 1);
    check("t3_last_head", req_addr, 32'h230);
    check("t3_last_wstrb", req_wstrb, 4'h3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    check("t3_drained", level, 0);

    // 4: ctrl-space address
    drive(1'b1, 32'h8000_0004, 32'h0, 4'h0);
    tick();
    drive(1'b0, '0, '0, '0);
    check("t4_ctrl", req_ctrl, 1);
    check("t4_addr", req_addr, 32'h4);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    check("t4_empty", level, 0);

    // 5: reset with three queued reads
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4*i), 32'h0, 4'h0);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    check("t5_level3", level, 3);
    rst = 1'b1;
    ack = 1'b1;
    #1;
    check("t5_rst_rvalid", rvalid, 0);
    check("t5_rst_ready", ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_level0", level, 0);
    check("t5_req_valid", req_valid, 0);
    check("t5_ack_rvalid", rvalid, 0);

    // 6: ack while empty, cke gating, saturation
    tick();
    ack = 1'b0;
    #1;
    check("t6_empty_ack_level", level, 0);
    cke = 1'b0;
    drive(1'b1, 32'h400, 32'h1, 4'h1);
    tick();
    check("t6_cke_level", level, 0);
    check("t6_cke_req_valid", req_valid, 0);
    cke = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(4*i), 32'(i), 4'hF);
      tick();
    end
    check("t6_full", level, 4);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    tick();
    check("t6_stall_max", stall, 32'hFFFF_FFFF);
    tick();
    check("t6_stall_sat", stall, 32'hFFFF_FFFF);
    cke = 1'b0;
    ack = 1'b1;
    #1;
    check("t6_cke_rvalid", rvalid, 0);
    tick();
    check("t6_cke_hold_level", level, 4);
    check("t6_cke_hold_stall", stall, 32'hFFFF_FFFF);
    ack = 1'b0;
    cke = 1'b1;
    drive(1'b0, '0, '0, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
